// File: rtl/wb_trace_pkg.sv
// Shared types and constants for the write-back trace buffer.
//   CYC_W   : width of the free-running cycle stamp
//   DROP_W  : width of the saturating drop counter
//   REG_W   : architectural register index width
package wb_trace_pkg;

  localparam int unsigned CYC_W  = 16;
  localparam int unsigned DROP_W = 8;
  localparam int unsigned REG_W  = 5;

  typedef struct packed {
    logic [4:0]       reg_num;
    logic [31:0]      data;
    logic [CYC_W-1:0] cycle;
  } trace_entry_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] value);
    return (&value) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/wb_trace_buffer_if.sv
// Show-ahead valid/ready trace port between the trace buffer and a debug sink.
//   master : buffer side, drives valid and head-entry fields, receives ready
//   slave  : sink side, receives valid and head-entry fields, drives ready
interface wb_trace_buffer_if #(
  parameter int unsigned DATA_W = 32
);
  import wb_trace_pkg::*;

  logic                  trc_valid;
  logic                  trc_ready;
  logic [REG_W-1:0]      trc_reg_num;
  logic [DATA_W-1:0]     trc_reg_data;
  logic [CYC_W-1:0]      trc_cycle;

  modport master (
    output trc_valid,
    output trc_reg_num,
    output trc_reg_data,
    output trc_cycle,
    input  trc_ready
  );

  modport slave (
    input  trc_valid,
    input  trc_reg_num,
    input  trc_reg_data,
    input  trc_cycle,
    output trc_ready
  );

endinterface

// File: rtl/trace_fifo.sv
// Generic show-ahead synchronous FIFO.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clear_i       : synchronous flush; overrides push and pop in the same cycle
//   push_i/data_i : write request and data (ignored when full unless popping)
//   pop_i         : read request (ignored when empty)
//   data_o        : head entry, forced to zero while empty
//   full_o, empty_o, count_o : occupancy status (count_o runs 0..Depth)
module trace_fifo #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 53,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AddrW:0]   count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AddrW:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AddrW+1)'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // Zero the head while empty so the port reads all-zero after reset.
  assign data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop_i && !empty_o && !clear_i;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    do_push  = push_i && !clear_i && (!full_o || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: it is only visible through data_o when non-empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/wb_trace_buffer.sv
// Write-back trace buffer: captures every retired non-x0 register write, stamps
// it with a free-running cycle count and queues it for a debug sink. Never
// stalls the core; writes arriving while full are dropped and counted.
//   clk, reset            : clock, asynchronous active-low reset
//   reg_write_sig/reg_num/reg_data : core write-back observation
//   clear                 : synchronous flush of queue, overflow and drop count
//   trc                   : show-ahead valid/ready trace port (master side)
//   count                 : queue occupancy 0..DEPTH
//   overflow, drop_cnt    : sticky drop flag and saturating drop counter
module wb_trace_buffer
  import wb_trace_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     reg_write_sig,
  input  logic [REG_W-1:0]         reg_num,
  input  logic [DATA_W-1:0]        reg_data,
  input  logic                     clear,
  wb_trace_buffer_if.master        trc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_cnt
);

  localparam int unsigned EntryW = REG_W + DATA_W + CYC_W;

  logic [CYC_W-1:0]  cyc_q;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic              capture, pop, drop;
  logic              full, empty;
  logic [EntryW-1:0] entry_in, entry_out;

  assign capture  = reg_write_sig && (reg_num != '0);
  assign entry_in = {reg_num, reg_data, cyc_q};

  trace_fifo #(
    .Depth (DEPTH),
    .Width (EntryW)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .clear_i (clear),
    .push_i  (capture),
    .data_i  (entry_in),
    .pop_i   (trc.trc_ready),
    .data_o  (entry_out),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign trc.trc_valid = !empty;
  assign {trc.trc_reg_num, trc.trc_reg_data, trc.trc_cycle} = entry_out;

  assign pop  = !empty && trc.trc_ready;
  // A simultaneous pop makes room, and clear suppresses the push entirely.
  assign drop = capture && full && !pop && !clear;

  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (clear) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      drop_cnt_d = sat_inc(drop_cnt_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_q      <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      cyc_q      <= cyc_q + 1'b1;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: doc/wb_trace_buffer.md
# wb_trace_buffer

Captures every architectural register write retired by the pipeline core's write-back stage, tags it with a cycle stamp, and buffers it in a FIFO. A valid/ready port drains the buffer to a debug sink, either a testbench scoreboard or a host link. Sits directly downstream of the core's `reg_write_sig` / `reg_num` / `reg_data` outputs and never back-pressures the core: when the buffer is full, entries are dropped and counted.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `DATA_W`, 32: register data width.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `reg_write_sig`  in  1  core write-back enable this cycle.
- `reg_num`  in  5  destination register index.
- `reg_data`  in  DATA_W  value written.
- `clear`  in  1  synchronous flush of FIFO and error state.
- `trc_valid`  out  1  head entry available.
- `trc_ready`  in  1  sink accepts head entry.
- `trc_reg_num`  out  5  head entry register index.
- `trc_reg_data`  out  DATA_W  head entry data.
- `trc_cycle`  out  16  head entry cycle stamp.
- `count`  out  $clog2(DEPTH)+1  current occupancy.
- `overflow`  out  1  sticky: at least one entry dropped.
- `drop_cnt`  out  8  dropped entries, saturating.

## Operation
- Capture condition: `reg_write_sig && reg_num != 0`. Writes to x0 are never captured and never counted as drops.
- Cycle counter: 16-bit, free-running; 0 in the first cycle after reset deassertion, +1 every cycle, wraps 0xFFFF→0x0000. Each entry is stamped with the counter value of its capture cycle.
- Push: capture and (not full, or pop this cycle) → write {reg_num, reg_data, stamp} at the write pointer; the write pointer advances.
- Drop: capture, full, and no pop this cycle → entry discarded; `overflow` ← 1; `drop_cnt` increments, saturating at 255.
- Pop: `trc_valid && trc_ready` → the read pointer advances.
- Simultaneous push and pop: both are performed and `count` is unchanged. This holds when full (no drop) and when count = 1.
- Pointers wrap modulo DEPTH. `count` runs 0..DEPTH.
- Output port is show-ahead:
  - `trc_valid` = (`count` != 0).
  - `trc_*` reflect the head entry and stay stable while `trc_valid && !trc_ready`.
  - `trc_*` are don't-care when `trc_valid` = 0; the bench checks them only when valid.
- `clear`:
  - Next cycle: `count` = 0; `overflow` = 0; `drop_cnt` = 0.
  - Any push or pop in the same cycle is ignored, and the ignored push is not a drop.
  - The cycle counter is not affected.
- Reset, asynchronous and active-low: `trc_valid`, `trc_reg_num`, `trc_reg_data`, `trc_cycle`, `count`, `overflow`, `drop_cnt`, both pointers and the cycle counter all go to 0 immediately. Reset mid-operation discards all buffered entries.

## Timing
- Capture-to-visible latency is 1 cycle. An entry captured in cycle N gives `trc_valid` = 1 in cycle N+1 at the earliest. There is no combinational bypass from `reg_*` to `trc_*`.
- `trc_valid`, `trc_*`, `count`, `overflow` and `drop_cnt` are registered or decoded from registers only. No input-to-output combinational path exists, including `trc_ready` → `trc_valid`.
- Sustained throughput is 1 entry per cycle when `trc_ready` is held at 1.
- A drop decision in cycle N is visible in `overflow` / `drop_cnt` in cycle N+1.

## Structure
- Package `wb_trace_pkg`:
  - `CYC_W` = 16, `DROP_W` = 8.
  - `typedef struct packed { logic [4:0] reg_num; logic [31:0] data; logic [CYC_W-1:0] cycle; } trace_entry_t`.
- Sub-module `trace_fifo`:
  - Generic synchronous FIFO, parameterised by DEPTH and entry width.
  - Ports: push/pop, full/empty/count, clear; same asynchronous active-low reset.
- Top level holds the capture filter, cycle counter, drop logic and error counters.

## Test plan
- Reset release, then write x5=0xDEADBEEF with `trc_ready`=0 → next cycle `trc_valid`=1, `trc_reg_num`=5, data 0xDEADBEEF, `trc_cycle`=capture-cycle stamp, `count`=1; outputs held until `trc_ready`=1.
- Write to x0 with data 0x1234 → `count` stays 0, `overflow` stays 0.
- 20 consecutive writes with `trc_ready`=0 and DEPTH=16 → `count`=16, `overflow`=1, `drop_cnt`=4; draining yields the first 16 entries in order.
- FIFO full, then capture and pop in the same cycle → `count` stays 16, `drop_cnt` unchanged, new entry appears last on drain.
- 300 dropped writes → `drop_cnt`=255 (saturated); then assert `clear` together with a capture → `count`=0, `overflow`=0, `drop_cnt`=0, no entry stored.
- Run past 65535 cycles, then capture → stamp wraps (e.g. 0x0003); assert `reset`=0 mid-drain → all outputs 0 immediately, FIFO empty after release.
